bram_dp_be: RTL and testbench
=============================

// Module: bram_dp_be
// PURPOSE
//  Simple dual-port byte-enable block RAM; successor to the 32-bit single-port user-project BRAM.
//  Adds parametrised width and depth, independent write and read ports, and selectable 1/2-cycle
//  read latency with a valid strobe. Also adds write-first collision forwarding and a sticky
//  out-of-range error flag. Used as tap/data buffer behind the FIR/AXI engines in user space.
// PARAMETERS
//  BIT_WIDTH   32  data word width; multiple of 8; NB = BIT_WIDTH/8 byte lanes
//  DEPTH       16  number of words stored
//  ADDR_WIDTH  12  width of byte addresses WA/RA
//  READ_LAT    1   read latency in cycles; legal values 1 or 2 (elaboration error otherwise)
// PORTS
//  CLK     in   1           clock; all logic on rising edge
//  RST     in   1           synchronous active-high reset
//  WEN     in   1           write port enable
//  WE      in   NB          byte-lane write strobes; lane i = Di[8i+7:8i]
//  WA      in   ADDR_WIDTH  write byte address
//  Di      in   BIT_WIDTH   write data
//  REN     in   1           read request
//  RA      in   ADDR_WIDTH  read byte address
//  Do      out  BIT_WIDTH   read data; holds last value between reads
//  Dvalid  out  1           1-cycle pulse: Do carries the result of a read request
//  ERR     out  1           sticky: out-of-range access seen since reset
// BEHAVIOUR
//  - Word index = addr >> log2(NB); low log2(NB) address bits ignored. In range iff index < DEPTH.
//  - Reset (RST=1 at edge): Do=0, Dvalid=0, ERR=0, read pipeline flushed. In-flight reads never
//    assert Dvalid. Memory array is NOT cleared. WEN/REN sampled during RST are ignored.
//  - Write: WEN=1, in range -> each lane with WE[i]=1 updated at the edge; other lanes unchanged.
//    WEN=1 with WE=0 is a legal no-op.
//  - Read: REN=1 sampled at edge T. READ_LAT=1 -> Do/Dvalid valid after edge T+1.
//    READ_LAT=2 -> after edge T+2. Back-to-back REN every cycle is fully pipelined:
//    one Dvalid per request, in request order.
//  - Collision, write-first: REN and WEN in the same cycle to the same in-range word.
//    The read returns stored word with the WE-selected lanes replaced by Di.
//    A write in any later cycle does not affect an already-sampled read.
//  - Out of range: write -> memory untouched, ERR<=1. Read -> Do=0 with normal Dvalid timing,
//    ERR<=1. ERR stays 1 until RST.
//  - Do is not masked by REN. It changes only on a Dvalid cycle or on reset.
//  - No read/write port conflict stalls. Both ports are always ready.
//  - Stage 1 (READ_LAT=2 only) holds raw array/forwarded word + valid bit.
//    The output stage registers Do/Dvalid.
// TESTING
//  1 Reset: RST high 2 cycles with REN=1 -> Do=0, Dvalid=0, ERR=0 throughout and 1 cycle after.
//  2 Byte lanes: write 0x11223344 to A=0x8 WE=4'hF, then Di=0xAABBCCDD WE=4'b0101.
//    Read A=0x8 -> Do=0x11BB33DD, Dvalid at T+READ_LAT only.
//  3 Collision: word 0x0 = 0xDEADBEEF; same cycle REN RA=0x0, WEN WA=0x0 WE=4'b1000 Di=0x55000000
//    -> Do=0x55ADBEEF. Repeat with WA=0x4 -> Do=0xDEADBEEF.
//  4 Pipelined reads: REN 4 consecutive cycles RA=0x0,0x4,0x8,0xC holding 1,2,3,4 (both latencies)
//    -> 4 consecutive Dvalid pulses, Do=1,2,3,4.
//  5 Range: DEPTH=16, write WA=0x40 -> ERR=1 next cycle, no word modified.
//    Read RA=0x40 -> Do=0, Dvalid=1. ERR holds until RST.
//  6 Reset mid-read: READ_LAT=2, REN at T, RST at T+1 -> no Dvalid; Do=0.
//    Memory contents preserved on next read.

Source files
------------

// File: rtl/bram_dp_be_if.sv
`default_nettype none
// ============================================================================
//  Module      : bram_dp_be_if
//  Description : Write/read port bundle for the byte-enable dual-port BRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bram_dp_be_if #(
    parameter int BIT_WIDTH  = 32,
    parameter int ADDR_WIDTH = 12
);
    localparam int c_NB = BIT_WIDTH / 8;

    logic                  WEN;
    logic [c_NB-1:0]       WE;
    logic [ADDR_WIDTH-1:0] WA;
    logic [BIT_WIDTH-1:0]  Di;
    logic                  REN;
    logic [ADDR_WIDTH-1:0] RA;
    logic [BIT_WIDTH-1:0]  Do;
    logic                  Dvalid;
    logic                  ERR;

    modport master (
        output WEN, WE, WA, Di, REN, RA,
        input  Do, Dvalid, ERR
    );

    modport slave (
        input  WEN, WE, WA, Di, REN, RA,
        output Do, Dvalid, ERR
    );
endinterface

`default_nettype wire

// File: rtl/bram_dp_be.sv
`default_nettype none
// ============================================================================
//  Module      : bram_dp_be
//  Description : Simple dual-port byte-enable BRAM, write-first forwarding,
//                1/2-cycle read latency with valid strobe, sticky range error.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_dp_be #(
    parameter int BIT_WIDTH  = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int READ_LAT   = 1
) (
    input  logic        CLK,
    input  logic        RST,
    bram_dp_be_if.slave bus
);
    localparam int c_NB  = BIT_WIDTH / 8;
    localparam int c_LSB = (c_NB > 1) ? $clog2(c_NB) : 0;
    localparam int c_IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [BIT_WIDTH-1:0] r_mem [DEPTH];

    logic [31:0]          w_wr_idx;
    logic [31:0]          w_rd_idx;
    logic                 w_wr_ok;
    logic                 w_rd_ok;
    logic                 w_wr_en;
    logic                 w_wr_hit;
    logic [BIT_WIDTH-1:0] w_rd_data;
    logic [BIT_WIDTH-1:0] w_out_data;
    logic                 w_out_vld;

    logic [BIT_WIDTH-1:0] r_do;
    logic                 r_dvalid;
    logic                 r_err;

    // Word index drops the byte-lane bits; widened to 32 bits for the range compare.
    assign w_wr_idx = 32'(bus.WA) >> c_LSB;
    assign w_rd_idx = 32'(bus.RA) >> c_LSB;
    assign w_wr_ok  = (w_wr_idx < 32'(DEPTH));
    assign w_rd_ok  = (w_rd_idx < 32'(DEPTH));
    assign w_wr_en  = bus.WEN & w_wr_ok & ~RST;
    assign w_wr_hit = w_wr_en & (w_wr_idx == w_rd_idx);

    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            for (int i = 0; i < c_NB; i++) begin
                if (bus.WE[i]) begin
                    r_mem[w_wr_idx[c_IW-1:0]][8*i +: 8] <= bus.Di[8*i +: 8];
                end
            end
        end
    end

    // Same-cycle write to the read word wins lane by lane.
    always_comb begin
        w_rd_data = '0;
        if (w_rd_ok) begin
            w_rd_data = r_mem[w_rd_idx[c_IW-1:0]];
            for (int i = 0; i < c_NB; i++) begin
                if (w_wr_hit && bus.WE[i]) begin
                    w_rd_data[8*i +: 8] = bus.Di[8*i +: 8];
                end
            end
        end
    end

    generate
        if ((BIT_WIDTH % 8) != 0 || BIT_WIDTH < 8) begin : g_bad_width
            $error("bram_dp_be: BIT_WIDTH must be a non-zero multiple of 8");
        end

        if (READ_LAT == 2) begin : g_lat2
            logic [BIT_WIDTH-1:0] r_s1_data;
            logic                 r_s1_vld;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_s1_vld  <= 1'b0;
                    r_s1_data <= '0;
                end else begin
                    r_s1_vld  <= bus.REN;
                    r_s1_data <= w_rd_data;
                end
            end

            assign w_out_vld  = r_s1_vld;
            assign w_out_data = r_s1_data;
        end else if (READ_LAT == 1) begin : g_lat1
            assign w_out_vld  = bus.REN;
            assign w_out_data = w_rd_data;
        end else begin : g_bad_lat
            $error("bram_dp_be: READ_LAT must be 1 or 2");
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_do     <= '0;
            r_dvalid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_dvalid <= w_out_vld;
            if (w_out_vld) begin
                r_do <= w_out_data;
            end
            if ((bus.WEN && !w_wr_ok) || (bus.REN && !w_rd_ok)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.Do     = r_do;
    assign bus.Dvalid = r_dvalid;
    assign bus.ERR    = r_err;
endmodule

`default_nettype wire

// File: tb/tb_bram_dp_be.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram_dp_be
//  Description : Directed bench driving a 1-cycle and a 2-cycle instance in lockstep.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_dp_be;
    logic        CLK;
    logic        rst;
    logic        wen;
    logic [3:0]  we;
    logic [11:0] wa;
    logic [31:0] di;
    logic        ren;
    logic [11:0] ra;

    int n_cmp;
    int n_bad;
    logic [31:0] last;
    logic [31:0] prev;

    bram_dp_be_if #(.BIT_WIDTH(32), .ADDR_WIDTH(12)) bus1 ();
    bram_dp_be_if #(.BIT_WIDTH(32), .ADDR_WIDTH(12)) bus2 ();

    assign bus1.WEN = wen;  assign bus2.WEN = wen;
    assign bus1.WE  = we;   assign bus2.WE  = we;
    assign bus1.WA  = wa;   assign bus2.WA  = wa;
    assign bus1.Di  = di;   assign bus2.Di  = di;
    assign bus1.REN = ren;  assign bus2.REN = ren;
    assign bus1.RA  = ra;   assign bus2.RA  = ra;

    bram_dp_be #(.BIT_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(12), .READ_LAT(1)) u_lat1 (
        .CLK (CLK),
        .RST (rst),
        .bus (bus1)
    );

    bram_dp_be #(.BIT_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(12), .READ_LAT(2)) u_lat2 (
        .CLK (CLK),
        .RST (rst),
        .bus (bus2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        wen;
        logic [3:0]  we;
        logic [11:0] wa;
        logic [31:0] di;
        logic        ren;
        logic [11:0] ra;
        logic [31:0] exp_do;
        logic        exp_err;
    } vec_t;

    localparam int NV = 17;
    vec_t tv [NV];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        wen = 1'b0; we = 4'h0; wa = '0; di = '0; ren = 1'b0; ra = '0;
    endtask

    task automatic chk_both_quiet(input string nm, input int idx);
        chk({nm, "_dv1"},  idx, 32'(bus1.Dvalid), 32'd0);
        chk({nm, "_do1"},  idx, bus1.Do, 32'd0);
        chk({nm, "_err1"}, idx, 32'(bus1.ERR), 32'd0);
        chk({nm, "_dv2"},  idx, 32'(bus2.Dvalid), 32'd0);
        chk({nm, "_do2"},  idx, bus2.Do, 32'd0);
        chk({nm, "_err2"}, idx, 32'(bus2.ERR), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        idle();
        rst = 1'b1;

        //                wen we    wa      di            ren ra      exp_do        err
        tv[0]  = '{1'b1, 4'hF, 12'h008, 32'h11223344, 1'b0, 12'h000, 32'h0,        1'b0};
        tv[1]  = '{1'b1, 4'h5, 12'h008, 32'hAABBCCDD, 1'b0, 12'h000, 32'h0,        1'b0};
        tv[2]  = '{1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 12'h008, 32'h11BB33DD, 1'b0};
        tv[3]  = '{1'b1, 4'hF, 12'h000, 32'hDEADBEEF, 1'b0, 12'h000, 32'h0,        1'b0};
        tv[4]  = '{1'b1, 4'h8, 12'h000, 32'h55000000, 1'b1, 12'h000, 32'h55ADBEEF, 1'b0};
        tv[5]  = '{1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 12'h000, 32'h55ADBEEF, 1'b0};
        tv[6]  = '{1'b1, 4'hF, 12'h000, 32'hDEADBEEF, 1'b0, 12'h000, 32'h0,        1'b0};
        tv[7]  = '{1'b1, 4'h8, 12'h004, 32'h55000000, 1'b1, 12'h000, 32'hDEADBEEF, 1'b0};
        tv[8]  = '{1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 12'h003, 32'hDEADBEEF, 1'b0};
        tv[9]  = '{1'b1, 4'h0, 12'h000, 32'hFFFFFFFF, 1'b1, 12'h000, 32'hDEADBEEF, 1'b0};
        tv[10] = '{1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 12'h000, 32'hDEADBEEF, 1'b0};
        tv[11] = '{1'b1, 4'hF, 12'h03C, 32'hCAFEF00D, 1'b0, 12'h000, 32'h0,        1'b0};
        tv[12] = '{1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 12'h03C, 32'hCAFEF00D, 1'b0};
        tv[13] = '{1'b1, 4'hF, 12'h040, 32'h99999999, 1'b0, 12'h000, 32'h0,        1'b1};
        tv[14] = '{1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 12'h000, 32'hDEADBEEF, 1'b1};
        tv[15] = '{1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 12'h040, 32'h00000000, 1'b1};
        tv[16] = '{1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 12'h03C, 32'hCAFEF00D, 1'b1};

        // Reset held two cycles with a read request pending
        ren = 1'b1; ra = 12'h000;
        tick(); chk_both_quiet("rst_a", 0);
        tick(); chk_both_quiet("rst_b", 0);
        rst = 1'b0; idle();
        tick(); chk_both_quiet("rst_c", 0);
        tick(); chk_both_quiet("rst_d", 0);

        // Pipelined reads: words 0..3 hold 1..4
        for (int k = 0; k < 4; k++) begin
            wen = 1'b1; we = 4'hF; wa = 12'(4 * k); di = 32'(k + 1);
            tick();
        end
        idle();
        for (int e = 1; e <= 6; e++) begin
            if (e <= 4) begin
                ren = 1'b1; ra = 12'(4 * (e - 1));
            end else begin
                ren = 1'b0; ra = '0;
            end
            tick();
            chk("pipe_dv1", e, 32'(bus1.Dvalid), (e <= 4) ? 32'd1 : 32'd0);
            chk("pipe_do1", e, bus1.Do, (e <= 4) ? 32'(e) : 32'd4);
            chk("pipe_dv2", e, 32'(bus2.Dvalid), (e >= 2 && e <= 5) ? 32'd1 : 32'd0);
            chk("pipe_do2", e, bus2.Do, (e < 2) ? 32'd0 : ((e <= 5) ? 32'(e - 1) : 32'd4));
        end
        last = 32'd4;

        // Table: each vector gets one active cycle then one idle drain cycle
        for (int k = 0; k < NV; k++) begin
            wen = tv[k].wen; we = tv[k].we; wa = tv[k].wa; di = tv[k].di;
            ren = tv[k].ren; ra = tv[k].ra;
            tick();
            prev = last;
            if (tv[k].ren) last = tv[k].exp_do;
            chk("tv_dv1",   k, 32'(bus1.Dvalid), 32'(tv[k].ren));
            chk("tv_do1",   k, bus1.Do, last);
            chk("tv_dv2e",  k, 32'(bus2.Dvalid), 32'd0);
            chk("tv_do2h",  k, bus2.Do, prev);
            chk("tv_err1",  k, 32'(bus1.ERR), 32'(tv[k].exp_err));
            chk("tv_err2",  k, 32'(bus2.ERR), 32'(tv[k].exp_err));
            idle();
            tick();
            chk("tv_dv1z",  k, 32'(bus1.Dvalid), 32'd0);
            chk("tv_do1h",  k, bus1.Do, last);
            chk("tv_dv2",   k, 32'(bus2.Dvalid), 32'(tv[k].ren));
            chk("tv_do2",   k, bus2.Do, last);
            chk("tv_err2b", k, 32'(bus2.ERR), 32'(tv[k].exp_err));
        end

        // Reset lands while the 2-cycle read is in stage 1
        ren = 1'b1; ra = 12'h000;
        tick();
        chk("midrst_dv1", 0, 32'(bus1.Dvalid), 32'd1);
        chk("midrst_do1", 0, bus1.Do, 32'hDEADBEEF);
        idle(); rst = 1'b1;
        tick(); chk_both_quiet("midrst_a", 0);
        rst = 1'b0;
        tick(); chk_both_quiet("midrst_b", 0);
        tick(); chk_both_quiet("midrst_c", 0);

        // Memory survives reset
        ren = 1'b1; ra = 12'h03C;
        tick();
        idle();
        chk("keep_dv1", 0, 32'(bus1.Dvalid), 32'd1);
        chk("keep_do1", 0, bus1.Do, 32'hCAFEF00D);
        chk("keep_dv2e", 0, 32'(bus2.Dvalid), 32'd0);
        tick();
        chk("keep_dv2", 0, 32'(bus2.Dvalid), 32'd1);
        chk("keep_do2", 0, bus2.Do, 32'hCAFEF00D);
        chk("keep_err1", 0, 32'(bus1.ERR), 32'd0);
        chk("keep_err2", 0, 32'(bus2.ERR), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
